// File: rtl/mm_result_buffer.sv
// Result FIFO plus credit-based issue control behind the 256-bit pipelined modular multiplier.
// Define MMRB_ERR_EN to add the sticky protocol-error output 'err'.
module mm_result_buffer #(
    parameter  int WIDTH = 256,
    parameter  int DEPTH = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    output logic             mul_in_valid,
    input  logic [WIDTH-1:0] mul_q,
    input  logic             mul_out_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CW-1:0]    occupancy,
    output logic [CW-1:0]    inflight
`ifdef MMRB_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_CW  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW:0]      credit_sum;
    logic             full;
    logic             pop;
    logic             push;
    logic             accept;
    logic             ret_stale;

    // Every issued multiplication owns a reserved slot, so the credit only
    // depends on registered counters and never on issue_valid.
    assign credit_sum   = {1'b0, occupancy} + {1'b0, inflight};
    assign issue_ready  = credit_sum < DEPTH_SUM;
    assign accept       = issue_valid && issue_ready;
    assign mul_in_valid = accept;

    assign res_valid = occupancy != '0;
    assign full      = occupancy == DEPTH_CW;
    assign pop       = res_valid && res_ready;
    assign push      = mul_out_valid && (!full || pop);
    assign ret_stale = mul_out_valid && (inflight == '0);

    // Storage is not reset, so the head is masked until something is stored.
    assign res_data = res_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= mul_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            inflight  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                occupancy <= occupancy + CW'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - CW'(1);
            end
            // A stale return with nothing in flight leaves the counter at zero.
            if (accept && !mul_out_valid) begin
                inflight <= inflight + CW'(1);
            end else if (mul_out_valid && !accept && !ret_stale) begin
                inflight <= inflight - CW'(1);
            end
        end
    end

`ifdef MMRB_ERR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((mul_out_valid && full && !pop) || ret_stale) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
